// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result queues feeding one registered
// broadcast bus. Round-robin grant order, optional mispredict priority,
// ROB flush and sticky overflow flags.
//
// Handshake: a result transfers into queue i on a rising edge where
// in_fu_done[i] and out_fu_ready[i] are both 1. out_fu_ready[i] is taken
// from the registered queue count only and never looks at in_fu_done.
// A result offered while out_fu_ready[i] is 0 is dropped and out_err[i]
// is set. The broadcast side has no backpressure: out_cdb_done is high for
// exactly one cycle per result.
module cdb_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int QDEPTH       = 2,
    parameter int VAL_W        = 64,
    parameter int ROB_IDX_W    = 4,
    parameter int MISPRED_PRIO = 1
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic [NUM_FU-1:0]           in_fu_done,
    input  logic [NUM_FU*ROB_IDX_W-1:0] in_fu_dst_rob_index,
    input  logic [NUM_FU*VAL_W-1:0]     in_fu_value,
    input  logic [NUM_FU-1:0]           in_fu_set_nzcv,
    input  logic [NUM_FU*4-1:0]         in_fu_nzcv,
    input  logic [NUM_FU-1:0]           in_fu_is_mispred,
    output logic [NUM_FU-1:0]           out_fu_ready,
    input  logic                        in_rob_flush,
    output logic                        out_cdb_done,
    output logic [ROB_IDX_W-1:0]        out_cdb_rob_index,
    output logic [VAL_W-1:0]            out_cdb_value,
    output logic                        out_cdb_set_nzcv,
    output logic [3:0]                  out_cdb_nzcv,
    output logic                        out_cdb_is_mispred,
    output logic [$clog2(NUM_FU)-1:0]   out_cdb_fu_id,
    output logic [NUM_FU-1:0]           out_err
);

    localparam int FU_ID_W = $clog2(NUM_FU);
    localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W   = $clog2(QDEPTH + 1);

    // Unpacked views of the flat FU input buses
    logic [ROB_IDX_W-1:0] w_in_idx  [NUM_FU];
    logic [VAL_W-1:0]     w_in_val  [NUM_FU];
    logic [3:0]           w_in_nzcv [NUM_FU];

    // Queue storage and control
    logic [ROB_IDX_W-1:0] r_q_idx  [NUM_FU][QDEPTH];
    logic [VAL_W-1:0]     r_q_val  [NUM_FU][QDEPTH];
    logic                 r_q_setf [NUM_FU][QDEPTH];
    logic [3:0]           r_q_nzcv [NUM_FU][QDEPTH];
    logic                 r_q_misp [NUM_FU][QDEPTH];
    logic [PTR_W-1:0]     r_wptr   [NUM_FU];
    logic [PTR_W-1:0]     r_rptr   [NUM_FU];
    logic [CNT_W-1:0]     r_count  [NUM_FU];

    // Queue heads
    logic [ROB_IDX_W-1:0] w_head_idx  [NUM_FU];
    logic [VAL_W-1:0]     w_head_val  [NUM_FU];
    logic                 w_head_setf [NUM_FU];
    logic [3:0]           w_head_nzcv [NUM_FU];
    logic                 w_head_misp [NUM_FU];

    logic [NUM_FU-1:0]    w_ready;
    logic [NUM_FU-1:0]    w_nonempty;
    logic [NUM_FU-1:0]    w_push;
    logic [NUM_FU-1:0]    w_pop;

    // Arbitration
    logic [FU_ID_W-1:0]   r_rr_ptr;
    logic                 w_arb_valid;
    logic                 w_grant_valid;
    logic [FU_ID_W-1:0]   w_grant_id;
    logic [FU_ID_W:0]     w_scan_sum;
    logic [FU_ID_W-1:0]   w_scan_id;
    logic [FU_ID_W-1:0]   w_rr_next;

    // Broadcast registers
    logic                 r_cdb_done;
    logic [ROB_IDX_W-1:0] r_cdb_idx;
    logic [VAL_W-1:0]     r_cdb_val;
    logic                 r_cdb_setf;
    logic [3:0]           r_cdb_nzcv;
    logic                 r_cdb_misp;
    logic [FU_ID_W-1:0]   r_cdb_fu_id;
    logic [NUM_FU-1:0]    r_err;

    genvar g;
    generate
        for (g = 0; g < NUM_FU; g++) begin : g_fu
            assign w_in_idx[g]    = in_fu_dst_rob_index[g*ROB_IDX_W +: ROB_IDX_W];
            assign w_in_val[g]    = in_fu_value[g*VAL_W +: VAL_W];
            assign w_in_nzcv[g]   = in_fu_nzcv[g*4 +: 4];

            assign w_head_idx[g]  = r_q_idx[g][r_rptr[g]];
            assign w_head_val[g]  = r_q_val[g][r_rptr[g]];
            assign w_head_setf[g] = r_q_setf[g][r_rptr[g]];
            assign w_head_nzcv[g] = r_q_nzcv[g][r_rptr[g]];
            assign w_head_misp[g] = r_q_misp[g][r_rptr[g]];

            // Ready is purely registered so FUs never see a combinational path
            assign w_ready[g]     = (r_count[g] < CNT_W'(QDEPTH));
            assign w_nonempty[g]  = (r_count[g] != '0);
            assign w_push[g]      = in_fu_done[g] && w_ready[g] && !in_rob_flush;
            assign w_pop[g]       = w_grant_valid && (w_grant_id == FU_ID_W'(g));
        end
    endgenerate

    // Grant selection: mispredicting heads first (lowest index), else round-robin
    always_comb begin
        w_arb_valid = 1'b0;
        w_grant_id  = '0;
        w_scan_sum  = '0;
        w_scan_id   = '0;
        if (MISPRED_PRIO != 0) begin
            for (int i = NUM_FU - 1; i >= 0; i--) begin
                if (w_nonempty[i] && w_head_misp[i]) begin
                    w_arb_valid = 1'b1;
                    w_grant_id  = FU_ID_W'(i);
                end
            end
        end
        if (!w_arb_valid) begin
            for (int k = 0; k < NUM_FU; k++) begin
                w_scan_sum = {1'b0, r_rr_ptr} + (FU_ID_W+1)'(k);
                if (w_scan_sum >= (FU_ID_W+1)'(NUM_FU)) begin
                    w_scan_sum = w_scan_sum - (FU_ID_W+1)'(NUM_FU);
                end
                w_scan_id = w_scan_sum[FU_ID_W-1:0];
                if (!w_arb_valid && w_nonempty[w_scan_id]) begin
                    w_arb_valid = 1'b1;
                    w_grant_id  = w_scan_id;
                end
            end
        end
    end

    // A flush cancels any grant in its cycle
    assign w_grant_valid = w_arb_valid && !in_rob_flush;
    assign w_rr_next     = (w_grant_id == FU_ID_W'(NUM_FU - 1)) ? '0 : w_grant_id + FU_ID_W'(1);

    // Queue pointers and occupancy counts
    always_ff @(posedge in_clk) begin
        if (in_rst || in_rob_flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_count[i] <= '0;
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= (r_wptr[i] == PTR_W'(QDEPTH - 1)) ? '0 : r_wptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= (r_rptr[i] == PTR_W'(QDEPTH - 1)) ? '0 : r_rptr[i] + PTR_W'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end else if (w_pop[i] && !w_push[i]) begin
                    r_count[i] <= r_count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Queue payload storage; contents are don't-care while a slot is empty
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_push[i] && !in_rst) begin
                r_q_idx[i][r_wptr[i]]  <= w_in_idx[i];
                r_q_val[i][r_wptr[i]]  <= w_in_val[i];
                r_q_setf[i][r_wptr[i]] <= in_fu_set_nzcv[i];
                r_q_nzcv[i][r_wptr[i]] <= w_in_nzcv[i];
                r_q_misp[i][r_wptr[i]] <= in_fu_is_mispred[i];
            end
        end
    end

    // Round-robin pointer advances past each granted FU; flush leaves it alone
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant_valid) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Broadcast register: payload holds when nothing is granted
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_cdb_done  <= 1'b0;
            r_cdb_idx   <= '0;
            r_cdb_val   <= '0;
            r_cdb_setf  <= 1'b0;
            r_cdb_nzcv  <= '0;
            r_cdb_misp  <= 1'b0;
            r_cdb_fu_id <= '0;
        end else begin
            r_cdb_done <= w_grant_valid;
            if (w_grant_valid) begin
                r_cdb_idx   <= w_head_idx[w_grant_id];
                r_cdb_val   <= w_head_val[w_grant_id];
                r_cdb_setf  <= w_head_setf[w_grant_id];
                r_cdb_nzcv  <= w_head_nzcv[w_grant_id];
                r_cdb_misp  <= w_head_misp[w_grant_id];
                r_cdb_fu_id <= w_grant_id;
            end
        end
    end

    // Sticky overflow flags, cleared only by reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | (in_fu_done & ~w_ready);
        end
    end

    assign out_fu_ready       = w_ready;
    assign out_cdb_done       = r_cdb_done;
    assign out_cdb_rob_index  = r_cdb_idx;
    assign out_cdb_value      = r_cdb_val;
    assign out_cdb_set_nzcv   = r_cdb_setf;
    assign out_cdb_nzcv       = r_cdb_nzcv;
    assign out_cdb_is_mispred = r_cdb_misp;
    assign out_cdb_fu_id      = r_cdb_fu_id;
    assign out_err            = r_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Two instances share the inputs: one with
// mispredict priority enabled, one with plain round-robin.
module tb_cdb_arbiter;

    localparam int NUM_FU    = 4;
    localparam int QDEPTH    = 2;
    localparam int VAL_W     = 64;
    localparam int ROB_IDX_W = 4;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NUM_FU-1:0]           fu_done;
    logic [NUM_FU*ROB_IDX_W-1:0] fu_idx;
    logic [NUM_FU*VAL_W-1:0]     fu_value;
    logic [NUM_FU-1:0]           fu_setf;
    logic [NUM_FU*4-1:0]         fu_nzcv;
    logic [NUM_FU-1:0]           fu_misp;
    logic                        flush;

    logic [NUM_FU-1:0]    ready,    np_ready;
    logic                 cdb_done, np_done;
    logic [ROB_IDX_W-1:0] cdb_idx,  np_idx;
    logic [VAL_W-1:0]     cdb_value, np_value;
    logic                 cdb_setf, np_setf;
    logic [3:0]           cdb_nzcv, np_nzcv;
    logic                 cdb_misp, np_misp;
    logic [1:0]           cdb_fu_id, np_fu_id;
    logic [NUM_FU-1:0]    err,      np_err;

    int errors = 0;
    int checks = 0;
    logic [VAL_W-1:0] exp_q[$];

    cdb_arbiter #(.NUM_FU(NUM_FU), .QDEPTH(QDEPTH), .VAL_W(VAL_W),
                  .ROB_IDX_W(ROB_IDX_W), .MISPRED_PRIO(1)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_fu_done(fu_done), .in_fu_dst_rob_index(fu_idx), .in_fu_value(fu_value),
        .in_fu_set_nzcv(fu_setf), .in_fu_nzcv(fu_nzcv), .in_fu_is_mispred(fu_misp),
        .out_fu_ready(ready), .in_rob_flush(flush),
        .out_cdb_done(cdb_done), .out_cdb_rob_index(cdb_idx), .out_cdb_value(cdb_value),
        .out_cdb_set_nzcv(cdb_setf), .out_cdb_nzcv(cdb_nzcv), .out_cdb_is_mispred(cdb_misp),
        .out_cdb_fu_id(cdb_fu_id), .out_err(err)
    );

    cdb_arbiter #(.NUM_FU(NUM_FU), .QDEPTH(QDEPTH), .VAL_W(VAL_W),
                  .ROB_IDX_W(ROB_IDX_W), .MISPRED_PRIO(0)) dut_np (
        .in_clk(clk), .in_rst(rst),
        .in_fu_done(fu_done), .in_fu_dst_rob_index(fu_idx), .in_fu_value(fu_value),
        .in_fu_set_nzcv(fu_setf), .in_fu_nzcv(fu_nzcv), .in_fu_is_mispred(fu_misp),
        .out_fu_ready(np_ready), .in_rob_flush(flush),
        .out_cdb_done(np_done), .out_cdb_rob_index(np_idx), .out_cdb_value(np_value),
        .out_cdb_set_nzcv(np_setf), .out_cdb_nzcv(np_nzcv), .out_cdb_is_mispred(np_misp),
        .out_cdb_fu_id(np_fu_id), .out_err(np_err)
    );

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fu_done  = '0;
        fu_idx   = '0;
        fu_value = '0;
        fu_setf  = '0;
        fu_nzcv  = '0;
        fu_misp  = '0;
        flush    = 1'b0;
    endtask

    task automatic drive_fu(input int i, input logic [3:0] idx, input logic [63:0] val,
                            input logic setf, input logic [3:0] nzcv, input logic misp);
        fu_done[i]          = 1'b1;
        fu_idx[i*4 +: 4]    = idx;
        fu_value[i*64 +: 64] = val;
        fu_setf[i]          = setf;
        fu_nzcv[i*4 +: 4]   = nzcv;
        fu_misp[i]          = misp;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (cdb_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", cdb_done); end
        checks++; if (ready !== 4'b1111) begin errors++; $display("FAIL reset_ready: got %b want 1111", ready); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", err); end
        checks++; if (cdb_value !== 64'd0) begin errors++; $display("FAIL reset_value: got %h want 0", cdb_value); end
        checks++; if (cdb_idx !== 4'd0 || cdb_fu_id !== 2'd0) begin
            errors++; $display("FAIL reset_idx_fu: got idx=%0d fu=%0d want 0/0", cdb_idx, cdb_fu_id);
        end
        checks++; if (np_done !== 1'b0 || np_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_np: got done=%b ready=%b want 0/1111", np_done, np_ready);
        end
    endtask

    task automatic test_single();
        clear_inputs();
        drive_fu(1, 4'd3, 64'h2A, 1'b0, 4'd0, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_done !== 1'b0) begin errors++; $display("FAIL single_c1_done: got %b want 0", cdb_done); end
        step();
        checks++; if (cdb_done !== 1'b1) begin errors++; $display("FAIL single_c2_done: got %b want 1", cdb_done); end
        checks++; if (cdb_idx !== 4'd3) begin errors++; $display("FAIL single_idx: got %0d want 3", cdb_idx); end
        checks++; if (cdb_value !== 64'h2A) begin errors++; $display("FAIL single_value: got %h want 2a", cdb_value); end
        checks++; if (cdb_fu_id !== 2'd1) begin errors++; $display("FAIL single_fu_id: got %0d want 1", cdb_fu_id); end
        step();
        checks++; if (cdb_done !== 1'b0) begin errors++; $display("FAIL single_c3_done: got %b want 0", cdb_done); end
        checks++; if (cdb_value !== 64'h2A) begin errors++; $display("FAIL single_hold: got %h want 2a", cdb_value); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < NUM_FU; i++) drive_fu(i, 4'(4 + i), 64'(256 + i), 1'b0, 4'd0, 1'b0);
        step();
        clear_inputs();
        for (int c = 0; c < NUM_FU; c++) begin
            step();
            checks++;
            if (cdb_done !== 1'b1 || cdb_fu_id !== 2'(c) || cdb_value !== 64'(256 + c) || cdb_idx !== 4'(4 + c)) begin
                errors++;
                $display("FAIL fair_order%0d: got done=%b fu=%0d val=%h idx=%0d want 1/%0d/%h/%0d",
                         c, cdb_done, cdb_fu_id, cdb_value, cdb_idx, c, 256 + c, 4 + c);
            end
        end
        // pointer is back at 0: FU0 must precede FU2
        drive_fu(0, 4'd8, 64'h200, 1'b0, 4'd0, 1'b0);
        drive_fu(2, 4'd9, 64'h202, 1'b0, 4'd0, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_done !== 1'b0) begin errors++; $display("FAIL fair_gap: got %b want 0", cdb_done); end
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_value !== 64'h200) begin
            errors++; $display("FAIL fair_fu0_first: got done=%b fu=%0d val=%h want 1/0/200", cdb_done, cdb_fu_id, cdb_value);
        end
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd2 || cdb_value !== 64'h202) begin
            errors++; $display("FAIL fair_fu2_second: got done=%b fu=%0d val=%h want 1/2/202", cdb_done, cdb_fu_id, cdb_value);
        end
    endtask

    task automatic test_back_to_back();
        int bcast;
        logic [VAL_W-1:0] exp_v;
        bcast = 0;
        apply_reset();
        exp_q.delete();
        exp_q.push_back(64'hA0);
        exp_q.push_back(64'hA1);
        exp_q.push_back(64'hA2);
        for (int c = 0; c < 24; c++) begin
            clear_inputs();
            if (c < 4) begin
                drive_fu(0, 4'd0, 64'(8'hA0 + c), 1'b0, 4'd0, 1'b0);
                for (int i = 1; i < NUM_FU; i++) drive_fu(i, 4'(i), 64'(8'hB0 + 16 * i + c), 1'b0, 4'd0, 1'b0);
            end
            if (c == 2) begin
                checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_c2: got %b want 1", ready[0]); end
            end
            if (c == 3) begin
                checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_c3: got %b want 0", ready[0]); end
                checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL bp_err_early: got %b want 0", err[0]); end
            end
            step();
            if (c == 3) begin
                checks++; if (err !== 4'b1111) begin errors++; $display("FAIL bp_err: got %b want 1111", err); end
            end
            if (cdb_done === 1'b1) begin
                bcast++;
                if (cdb_fu_id === 2'd0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL bp_fu0_extra: got %h want none", cdb_value);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (cdb_value !== exp_v) begin
                            errors++; $display("FAIL bp_fu0_order: got %h want %h", cdb_value, exp_v);
                        end
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_fu0_missing: got %0d left want 0", exp_q.size()); end
        checks++; if (bcast != 10) begin errors++; $display("FAIL bp_total: got %0d want 10", bcast); end
        checks++; if (ready !== 4'b1111 || cdb_done !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got ready=%b done=%b want 1111/0", ready, cdb_done);
        end
    endtask

    task automatic test_mispred();
        apply_reset();
        drive_fu(0, 4'd1, 64'hC0, 1'b0, 4'b0000, 1'b0);
        drive_fu(3, 4'd2, 64'hC3, 1'b1, 4'b1010, 1'b1);
        step();
        clear_inputs();
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd3 || cdb_misp !== 1'b1 || cdb_value !== 64'hC3) begin
            errors++; $display("FAIL misp_first: got done=%b fu=%0d misp=%b val=%h want 1/3/1/c3", cdb_done, cdb_fu_id, cdb_misp, cdb_value);
        end
        checks++; if (cdb_setf !== 1'b1 || cdb_nzcv !== 4'b1010 || cdb_idx !== 4'd2) begin
            errors++; $display("FAIL misp_fields: got setf=%b nzcv=%b idx=%0d want 1/1010/2", cdb_setf, cdb_nzcv, cdb_idx);
        end
        checks++; if (np_done !== 1'b1 || np_fu_id !== 2'd0 || np_misp !== 1'b0 || np_value !== 64'hC0) begin
            errors++; $display("FAIL noprio_first: got done=%b fu=%0d misp=%b val=%h want 1/0/0/c0", np_done, np_fu_id, np_misp, np_value);
        end
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_misp !== 1'b0) begin
            errors++; $display("FAIL misp_second: got done=%b fu=%0d misp=%b want 1/0/0", cdb_done, cdb_fu_id, cdb_misp);
        end
        checks++; if (np_done !== 1'b1 || np_fu_id !== 2'd3 || np_misp !== 1'b1) begin
            errors++; $display("FAIL noprio_second: got done=%b fu=%0d misp=%b want 1/3/1", np_done, np_fu_id, np_misp);
        end
        // prio instance rr=1, noprio rr=0: lowest mispredicting FU beats rr order
        drive_fu(1, 4'd5, 64'hD1, 1'b0, 4'd0, 1'b0);
        drive_fu(2, 4'd6, 64'hD2, 1'b0, 4'd0, 1'b1);
        drive_fu(3, 4'd7, 64'hD3, 1'b0, 4'd0, 1'b1);
        step();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (cdb_done !== 1'b1 || cdb_fu_id !== ((c == 0) ? 2'd2 : (c == 1) ? 2'd3 : 2'd1)) begin
                errors++; $display("FAIL misp_multi%0d: got done=%b fu=%0d", c, cdb_done, cdb_fu_id);
            end
            checks++;
            if (np_done !== 1'b1 || np_fu_id !== 2'(c + 1)) begin
                errors++; $display("FAIL noprio_multi%0d: got done=%b fu=%0d want 1/%0d", c, np_done, np_fu_id, c + 1);
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive_fu(0, 4'd1, 64'hD0, 1'b0, 4'd0, 1'b0);
        drive_fu(1, 4'd2, 64'hD1, 1'b0, 4'd0, 1'b0);
        drive_fu(2, 4'd3, 64'hD2, 1'b0, 4'd0, 1'b0);
        step();
        clear_inputs();
        drive_fu(3, 4'd4, 64'hD3, 1'b0, 4'd0, 1'b0);
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_value !== 64'hD0) begin
            errors++; $display("FAIL flush_pre: got done=%b fu=%0d val=%h want 1/0/d0", cdb_done, cdb_fu_id, cdb_value);
        end
        // three results queued (FU1..3); flush with a concurrent FU1 push
        clear_inputs();
        flush = 1'b1;
        drive_fu(1, 4'd9, 64'hE1, 1'b0, 4'd0, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", cdb_done); end
        checks++; if (ready !== 4'b1111) begin errors++; $display("FAIL flush_ready: got %b want 1111", ready); end
        checks++; if (cdb_value !== 64'hD0 || err !== 4'b0000) begin
            errors++; $display("FAIL flush_hold: got val=%h err=%b want d0/0000", cdb_value, err);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (cdb_done !== 1'b0) begin errors++; $display("FAIL flush_idle%0d: got %b want 0", c, cdb_done); end
        end
        // rr pointer survived the flush at 1: FU1 goes before FU0
        drive_fu(0, 4'd1, 64'hF0, 1'b0, 4'd0, 1'b0);
        drive_fu(1, 4'd2, 64'hF1, 1'b0, 4'd0, 1'b0);
        step();
        clear_inputs();
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd1 || cdb_value !== 64'hF1) begin
            errors++; $display("FAIL flush_rr_first: got done=%b fu=%0d val=%h want 1/1/f1", cdb_done, cdb_fu_id, cdb_value);
        end
        step();
        checks++; if (cdb_done !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_value !== 64'hF0) begin
            errors++; $display("FAIL flush_rr_second: got done=%b fu=%0d val=%h want 1/0/f0", cdb_done, cdb_fu_id, cdb_value);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_mispred();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
